// File: rtl/game_pkg.sv
// Shared game types and scroll-stage constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [1:0] {
        GS_MENU = 2'd0,
        GS_PLAY = 2'd1,
        GS_OVER = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        EMIT = 2'd2
    } scroll_state_t;

    localparam int SCREEN_H      = 480;
    localparam int Y_W           = 10;
    localparam int SCROLL_LINE   = 200;
    localparam int MAX_STEP      = 8;
    localparam int SPAWN_SPACING = 60;
    localparam int HEIGHT_W      = 20;
    localparam int PEND_W        = 3;
    localparam int ACC_W         = 7;

    // Scroll step for one frame: the overshoot, limited to the per-frame cap.
    function automatic logic [Y_W-1:0] clamp_step(input logic [Y_W-1:0] need,
                                                  input logic [Y_W-1:0] cap);
        return (need < cap) ? need : cap;
    endfunction

endpackage

// File: rtl/scroll_controller_if.sv
// Scroll controller bus: doodle/game inputs in, scroll pulse, height and spawn handshake out.
// Latency: n/a (wires only).
// Backpressure: spawn_req/spawn_ack is a level-request / one-cycle-accept handshake.
// Ports: master = game-side driver, slave = scroll_controller.
interface scroll_controller_if;
    import game_pkg::*;

    logic                frame_tick;
    game_state_t         game_state;
    logic [Y_W-1:0]      doodle_y;
    logic                doodle_fall_direction;
    logic                scroll_valid;
    logic [Y_W-1:0]      scroll_delta;
    logic [HEIGHT_W-1:0] height;
    logic                spawn_req;
    logic                spawn_ack;

    modport master (
        output frame_tick, game_state, doodle_y, doodle_fall_direction, spawn_ack,
        input  scroll_valid, scroll_delta, height, spawn_req
    );

    modport slave (
        input  frame_tick, game_state, doodle_y, doodle_fall_direction, spawn_ack,
        output scroll_valid, scroll_delta, height, spawn_req
    );

endinterface

// File: rtl/spawn_credit_counter.sv
// Spawn bookkeeping: accumulates scrolled pixels and counts pending spawn credits.
// Latency: add/ack visible on spawn_req_o the cycle after they are sampled.
// Backpressure: credits saturate at all-ones; extra credits are dropped, acks at zero ignored.
// Ports: clk, rst, add_i/step_i (scroll amount), ack_i, clear_i (wins), freeze_i, spawn_req_o.
module spawn_credit_counter #(
    parameter int ACC_W   = 7,
    parameter int CNT_W   = 3,
    parameter int STEP_W  = 4,
    parameter int SPACING = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              ack_i,
    input  logic              clear_i,
    input  logic              freeze_i,
    output logic              spawn_req_o
);
    localparam logic [ACC_W:0] SPC = (ACC_W+1)'(SPACING);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             req_q;
    logic [ACC_W:0]   sum;
    logic             inc;
    logic             ack_ok;

    always_comb begin
        sum    = {1'b0, acc_q} + {{(ACC_W+1-STEP_W){1'b0}}, step_i};
        acc_d  = acc_q;
        inc    = 1'b0;
        // Step is always below the spacing, so one subtraction suffices.
        if (add_i && !freeze_i) begin
            if (sum >= SPC) begin
                acc_d = ACC_W'(sum - SPC);
                inc   = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
        ack_ok = ack_i && (pend_q != '0);
        pend_d = pend_q;
        // inc together with an accepted ack cancels out, including at saturation.
        if (inc && !ack_ok && !(&pend_q)) begin
            pend_d = pend_q + 1'b1;
        end else if (!inc && ack_ok) begin
            pend_d = pend_q - 1'b1;
        end
        if (clear_i) begin
            acc_d  = '0;
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            pend_q <= '0;
            req_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            pend_q <= pend_d;
            req_q  <= (pend_d != '0);
        end
    end

    assign spawn_req_o = req_q;

endmodule

// File: rtl/scroll_controller.sv
// Converts doodle overshoot above the scroll line into one clamped scroll pulse per frame.
// Latency: frame_tick at cycle t -> scroll_valid at t+2; height/spawn_req update at t+3.
// Backpressure: none on scroll (consumers must take the pulse); ticks during EVAL/EMIT are dropped.
// Ports: clk, rst (async, active high), bus (scroll_controller_if.slave).
module scroll_controller
    import game_pkg::*;
(
    input  logic clk,
    input  logic rst,
    scroll_controller_if.slave bus
);
    localparam logic [Y_W-1:0] LINE     = Y_W'(SCROLL_LINE);
    localparam logic [Y_W-1:0] STEP_MAX = Y_W'(MAX_STEP);
    localparam int             STEP_W   = $clog2(MAX_STEP + 1);

    scroll_state_t       state_q;
    logic [Y_W-1:0]      y_q;
    logic                fall_q;
    logic                valid_q;
    logic [Y_W-1:0]      delta_q;
    logic [HEIGHT_W-1:0] height_q;
    logic [HEIGHT_W:0]   height_sum;
    logic                play, menu, over;

    assign play       = (bus.game_state == GS_PLAY);
    assign menu       = (bus.game_state == GS_MENU);
    assign over       = (bus.game_state == GS_OVER);
    assign height_sum = {1'b0, height_q} + (HEIGHT_W+1)'(delta_q);

    // delta_q doubles as the step register: written in EVAL, consumed in EMIT,
    // and held afterwards so the output keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            y_q      <= '0;
            fall_q   <= 1'b0;
            valid_q  <= 1'b0;
            delta_q  <= '0;
            height_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.frame_tick) begin
                        y_q     <= bus.doodle_y;
                        fall_q  <= bus.doodle_fall_direction;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    // Live game_state is used here, not the one at the tick.
                    if (play && !fall_q && (y_q < LINE)) begin
                        valid_q <= 1'b1;
                        delta_q <= clamp_step(LINE - y_q, STEP_MAX);
                        state_q <= EMIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EMIT:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (menu) begin
                height_q <= '0;
            end else if ((state_q == EMIT) && !over) begin
                height_q <= height_sum[HEIGHT_W] ? '1 : height_sum[HEIGHT_W-1:0];
            end
        end
    end

    spawn_credit_counter #(
        .ACC_W  (ACC_W),
        .CNT_W  (PEND_W),
        .STEP_W (STEP_W),
        .SPACING(SPAWN_SPACING)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .add_i      (state_q == EMIT),
        .step_i     (delta_q[STEP_W-1:0]),
        .ack_i      (bus.spawn_ack),
        .clear_i    (menu),
        .freeze_i   (over),
        .spawn_req_o(bus.spawn_req)
    );

    assign bus.scroll_valid = valid_q;
    assign bus.scroll_delta = delta_q;
    assign bus.height       = height_q;

endmodule

// File: tb/tb_scroll_controller.sv
// Testbench for scroll_controller: vector table, directed corner sequences, randomized frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_scroll_controller;
    import game_pkg::*;

    localparam int HMAX = (1 << HEIGHT_W) - 1;
    localparam int PMAX = (1 << PEND_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scroll_controller_if bus();
    scroll_controller dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    // Reference state: what the spec says the world should look like.
    int m_height, m_acc, m_pend;

    typedef struct {
        int y;
        bit dir;
        bit exp_v;
        int exp_d;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_delta(input game_state_t gs, input int y, input bit dir);
        int need;
        if (gs != GS_PLAY || dir || y >= SCROLL_LINE) return 0;
        need = SCROLL_LINE - y;
        return (need > MAX_STEP) ? MAX_STEP : need;
    endfunction

    task automatic model_clear();
        m_height = 0;
        m_acc    = 0;
        m_pend   = 0;
    endtask

    task automatic model_frame(input game_state_t gs, input int d, input bit ack);
        bit inc;
        inc = 1'b0;
        if (gs == GS_MENU) begin
            model_clear();
            return;
        end
        if (gs == GS_PLAY && d > 0) begin
            m_height = (m_height + d > HMAX) ? HMAX : m_height + d;
            m_acc    = m_acc + d;
            if (m_acc >= SPAWN_SPACING) begin
                m_acc = m_acc - SPAWN_SPACING;
                inc   = 1'b1;
            end
        end
        if (inc && ack && m_pend > 0) begin
            // accepted spawn and new credit cancel
        end else if (inc) begin
            m_pend = (m_pend < PMAX) ? m_pend + 1 : PMAX;
        end else if (ack && m_pend > 0) begin
            m_pend = m_pend - 1;
        end
    endtask

    // Called right after a negedge; returns at the negedge after the EMIT slot.
    task automatic frame(input game_state_t gs, input int y, input bit dir, input bit ack,
                         input bit exp_v, input int exp_d);
        bus.game_state            = gs;
        bus.doodle_y              = Y_W'(y);
        bus.doodle_fall_direction = dir;
        bus.frame_tick            = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        check("valid_t1", int'(bus.scroll_valid), 0);
        @(negedge clk);
        check("valid_t2", int'(bus.scroll_valid), int'(exp_v));
        if (exp_v) check("delta", int'(bus.scroll_delta), exp_d);
        bus.spawn_ack = ack;
        @(negedge clk);
        bus.spawn_ack = 1'b0;
        model_frame(gs, model_delta(gs, y, dir), ack);
        check("valid_t3", int'(bus.scroll_valid), 0);
        if (exp_v) check("delta_hold", int'(bus.scroll_delta), exp_d);
        check("height", int'(bus.height), m_height);
        check("spawn_req", int'(bus.spawn_req), int'(m_pend != 0));
        check("pending", int'(dut.u_credit.pend_q), m_pend);
    endtask

    task automatic ack_one();
        bus.spawn_ack = 1'b1;
        @(negedge clk);
        bus.spawn_ack = 1'b0;
        if (bus.game_state == GS_MENU) model_clear();
        else if (m_pend > 0) m_pend = m_pend - 1;
        check("ack_req", int'(bus.spawn_req), int'(m_pend != 0));
        check("ack_pend", int'(dut.u_credit.pend_q), m_pend);
    endtask

    initial begin
        int pulses;
        int r, y, d;
        bit dir, ack;
        game_state_t gs;

        tbl[0] = '{150, 1'b0, 1'b1, 8};
        tbl[1] = '{196, 1'b0, 1'b1, 4};
        tbl[2] = '{200, 1'b0, 1'b0, 0};
        tbl[3] = '{150, 1'b1, 1'b0, 0};
        tbl[4] = '{199, 1'b0, 1'b1, 1};
        tbl[5] = '{192, 1'b0, 1'b1, 8};
        tbl[6] = '{0,   1'b0, 1'b1, 8};
        tbl[7] = '{193, 1'b0, 1'b1, 7};

        rst                       = 1'b1;
        bus.frame_tick            = 1'b0;
        bus.game_state            = GS_MENU;
        bus.doodle_y              = '0;
        bus.doodle_fall_direction = 1'b0;
        bus.spawn_ack             = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_valid", int'(bus.scroll_valid), 0);
        check("rst_delta", int'(bus.scroll_delta), 0);
        check("rst_height", int'(bus.height), 0);
        check("rst_spawn_req", int'(bus.spawn_req), 0);
        check("rst_state", int'(dut.state_q), int'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Basic scroll vectors; heights accumulate 8,12,12,12,13,21,29,36.
        for (int i = 0; i < 8; i++)
            frame(GS_PLAY, tbl[i].y, tbl[i].dir, 1'b0, tbl[i].exp_v, tbl[i].exp_d);
        check("tbl_height", int'(bus.height), 36);

        bus.game_state = GS_MENU;
        @(negedge clk);
        model_clear();
        check("menu_height", int'(bus.height), 0);
        check("menu_acc", int'(dut.u_credit.acc_q), 0);

        // Eight full steps: 64 px -> acc 4, one pending credit.
        for (int i = 0; i < 8; i++) frame(GS_PLAY, 150, 1'b0, 1'b0, 1'b1, 8);
        check("spawn_acc", int'(dut.u_credit.acc_q), 4);
        check("spawn_pend", int'(dut.u_credit.pend_q), 1);
        check("spawn_req_up", int'(bus.spawn_req), 1);
        ack_one();
        check("spawn_req_down", int'(bus.spawn_req), 0);

        // 14 frames give one new credit and acc 56; the 15th wraps with an ack.
        for (int i = 0; i < 14; i++) frame(GS_PLAY, 150, 1'b0, 1'b0, 1'b1, 8);
        check("pre_coinc_pend", int'(dut.u_credit.pend_q), 1);
        frame(GS_PLAY, 150, 1'b0, 1'b1, 1'b1, 8);
        check("coinc_pend", int'(dut.u_credit.pend_q), 1);

        // Push well past saturation, then drain.
        for (int i = 0; i < 70; i++) frame(GS_PLAY, 0, 1'b0, 1'b0, 1'b1, 8);
        check("sat_pend", int'(dut.u_credit.pend_q), 7);
        check("sat_req", int'(bus.spawn_req), 1);
        for (int i = 0; i < 7; i++) ack_one();
        check("drain_req", int'(bus.spawn_req), 0);
        ack_one();
        check("ack_at_zero", int'(dut.u_credit.pend_q), 0);

        for (int i = 0; i < 8; i++) frame(GS_PLAY, 0, 1'b0, 1'b0, 1'b1, 8);
        bus.game_state = GS_MENU;
        @(negedge clk);
        model_clear();
        check("menu2_height", int'(bus.height), 0);
        check("menu2_acc", int'(dut.u_credit.acc_q), 0);
        check("menu2_pend", int'(dut.u_credit.pend_q), 0);
        check("menu2_req", int'(bus.spawn_req), 0);
        frame(GS_MENU, 100, 1'b0, 1'b0, 1'b0, 0);

        // frame_tick held through EVAL and EMIT must give a single pulse.
        bus.game_state            = GS_PLAY;
        bus.doodle_y              = Y_W'(100);
        bus.doodle_fall_direction = 1'b0;
        bus.frame_tick            = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) bus.frame_tick = 1'b0;
            pulses += int'(bus.scroll_valid);
        end
        model_frame(GS_PLAY, 8, 1'b0);
        check("tick_in_eval_pulses", pulses, 1);
        check("tick_in_eval_height", int'(bus.height), m_height);

        // Game over: no scrolling, height frozen.
        for (int i = 0; i < 3; i++) frame(GS_OVER, 100, 1'b0, 1'b0, 1'b0, 0);
        check("over_height", int'(bus.height), 8);

        // Randomized frames against the model.
        for (int i = 0; i < 80; i++) begin
            r   = int'($urandom_range(0, 9));
            gs  = (r == 0) ? GS_MENU : (r == 1) ? GS_OVER : GS_PLAY;
            y   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(150, 230))
                                              : int'($urandom_range(0, SCREEN_H - 1));
            dir = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 9) < 3);
            d   = model_delta(gs, y, dir);
            frame(gs, y, dir, ack, d != 0, d);
        end

        // Asynchronous reset while the pulse is on the output.
        model_clear();
        bus.game_state            = GS_PLAY;
        bus.doodle_y              = Y_W'(150);
        bus.doodle_fall_direction = 1'b0;
        bus.frame_tick            = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", int'(bus.scroll_valid), 1);
        rst = 1'b1;
        #1;
        check("arst_valid", int'(bus.scroll_valid), 0);
        check("arst_delta", int'(bus.scroll_delta), 0);
        check("arst_height", int'(bus.height), 0);
        check("arst_req", int'(bus.spawn_req), 0);
        check("arst_state", int'(dut.state_q), int'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            pulses += int'(bus.scroll_valid);
        end
        check("post_rst_pulses", pulses, 0);
        check("post_rst_height", int'(bus.height), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/scroll_controller.md
Name: scroll_controller

Overview:
- Sits between the doodle and the platform stages; converts doodle upward overshoot into per-frame world-scroll steps.
- Once per frame, while playing and the doodle rises above SCROLL_LINE, emits a one-cycle scroll pulse with a clamped pixel delta. Platforms and the doodle consume that delta.
- Accumulates total climbed height for scoring.
- Issues a platform-spawn request each time SPAWN_SPACING pixels have scrolled.

Parameters:
- SCROLL_LINE, 200: screen y (0 = top) above which scrolling starts.
- MAX_STEP, 8: maximum scroll pixels per frame.
- SPAWN_SPACING, 60: scrolled pixels per spawn request.
- HEIGHT_W, 20: width of the height accumulator.
- PEND_W, 3: width of the pending-spawn counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- frame_tick  in  1  one-cycle pulse per frame (fps_counter wrap)
- game_state  in  2  game_pkg::game_state_t
- doodle_y  in  10  doodle top y, screen coordinates
- doodle_fall_direction  in  1  0 = moving up, 1 = falling
- scroll_valid  out  1  one-cycle pulse; scroll_delta is valid in that cycle
- scroll_delta  out  10  pixels to shift the world down; range 1..MAX_STEP
- height  out  HEIGHT_W  total scrolled pixels, saturating
- spawn_req  out  1  high while pending spawns are greater than 0
- spawn_ack  in  1  consumer accepts one spawn in a cycle where spawn_req is high

Behaviour:
- Reset (async, active-high): state = IDLE, scroll_valid = 0, scroll_delta = 0, height = 0, spawn accumulator = 0, pending = 0, spawn_req = 0.
- FSM states:
  - IDLE: on frame_tick, latch doodle_y and doodle_fall_direction, then go to EVAL.
  - EVAL: if game_state == GS_PLAY, fall_direction == 0 and y_latched < SCROLL_LINE, compute need = SCROLL_LINE - y_latched and step = min(need, MAX_STEP), then go to EMIT. Otherwise return to IDLE with no pulse.
  - EMIT: scroll_valid = 1 and scroll_delta = step for exactly one cycle; height += step (saturate at all-ones); acc += step. Return to IDLE.
- Latency: frame_tick at cycle t gives scroll_valid at t+2. At most one pulse per frame.
- A frame_tick arriving while in EVAL or EMIT is ignored, never queued.
- scroll_delta holds its last value when scroll_valid = 0. Consumers must qualify on scroll_valid.
- Spawn accumulator (7 bits): on the EMIT update, if acc + step >= SPAWN_SPACING, then acc = acc + step - SPAWN_SPACING and pending increments. Because MAX_STEP < SPAWN_SPACING, at most one increment per EMIT.
- Pending counter:
  - Increment and spawn_ack in the same cycle: net unchanged.
  - Saturates at 2^PEND_W - 1; further increments are dropped.
  - spawn_ack while pending == 0 is ignored.
  - spawn_req = (pending != 0), registered from the counter.
- game_state == GS_MENU: synchronously clear height, acc and pending every cycle; FSM still runs but EVAL never scrolls.
- game_state == GS_OVER: freeze height, acc and pending; spawn_ack is still honoured.
- game_state change between the frame_tick latch and EVAL: EVAL uses the live game_state.
- Arithmetic is unsigned. need is computed only when y_latched < SCROLL_LINE, so it never underflows.

Decomposition:
- game_pkg holds:
  - game_state_t enum: GS_MENU = 2'd0, GS_PLAY = 2'd1, GS_OVER = 2'd2.
  - scroll_state_t enum: IDLE, EVAL, EMIT.
  - SCREEN_H = 480.
- Sub-module spawn_credit_counter: accumulator plus pending counter with inc/ack/clear/freeze controls, so spawn bookkeeping can be verified in isolation.

Test Plan:
1. Reset mid-EMIT → all outputs 0 immediately (async), FSM back in IDLE, no pulse after release.
2. GS_PLAY, y = 150, up, frame_tick at t → scroll_valid only at t+2 with delta = 8, height = 8. With y = 196 → delta = 4.
3. y = 200 or fall_direction = 1 → no scroll_valid, height unchanged.
4. 8 frames at delta 8 → acc = 4, pending = 1, spawn_req rises after the 8th EMIT; spawn_ack → spawn_req = 0. Ack coinciding with the next increment → pending stays 1.
5. Pending reaches 7 with no ack → spawn_req held, a further increment is dropped, 7 acks clear it. GS_MENU → height, acc and pending cleared next cycle.
6. frame_tick during EVAL → ignored, exactly one pulse. GS_OVER → no pulses, height frozen.
